// File: rtl/bp_cfg_loader.sv
// Boot-time configuration sequencer: freezes all cores, programs core IDs, loads CCE
// microcode from a synchronous ROM, sets CCE mode and unfreezes, with credit flow control.
module bp_cfg_loader #(
    parameter int num_core_p          = 2,
    parameter int cce_instr_ram_els_p = 256,
    parameter int cce_instr_width_p   = 64,
    parameter int cfg_addr_width_p    = 16,
    parameter int data_width_p        = 64,
    parameter int max_credits_p       = 4,
    localparam int core_w   = (num_core_p > 1) ? $clog2(num_core_p) : 1,
    localparam int instr_w  = (cce_instr_ram_els_p > 1) ? $clog2(cce_instr_ram_els_p) : 1,
    localparam int credit_w = $clog2(max_credits_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    output logic                         cfg_v_o,
    input  logic                         cfg_ready_i,
    output logic [core_w-1:0]            cfg_core_o,
    output logic [cfg_addr_width_p-1:0]  cfg_addr_o,
    output logic [data_width_p-1:0]      cfg_data_o,
    input  logic                         cfg_ack_i,
    output logic [instr_w-1:0]           rom_addr_o,
    input  logic [cce_instr_width_p-1:0] rom_data_i,
    output logic                         done_o
);

    localparam logic [cfg_addr_width_p-1:0] freeze_addr   = cfg_addr_width_p'(16'h0008);
    localparam logic [cfg_addr_width_p-1:0] core_id_addr  = cfg_addr_width_p'(16'h0010);
    localparam logic [cfg_addr_width_p-1:0] cce_mode_addr = cfg_addr_width_p'(16'h0018);
    localparam logic [cfg_addr_width_p-1:0] ucode_base    = cfg_addr_width_p'(16'h8000);

    typedef enum logic [3:0] {
        e_reset, e_freeze, e_core_id, e_ucode, e_mode,
        e_drain, e_unfreeze, e_drain2, e_done
    } state_e;

    state_e                state, state_n;
    logic [core_w-1:0]     core_cnt;
    logic [instr_w-1:0]    instr_cnt;
    logic [credit_w-1:0]   credits;
    logic                  rom_valid;
    logic                  write_state, hs, last_core, last_instr, last_elem;

    always_comb begin
        write_state = state inside {e_freeze, e_core_id, e_ucode, e_mode, e_unfreeze};
        cfg_v_o     = write_state && (credits < credit_w'(max_credits_p))
                      && ((state != e_ucode) || rom_valid);
        hs          = cfg_v_o && cfg_ready_i;
        last_core   = (core_cnt == core_w'(num_core_p - 1));
        last_instr  = (instr_cnt == instr_w'(cce_instr_ram_els_p - 1));
        last_elem   = last_core && ((state != e_ucode) || last_instr);
        done_o      = (state == e_done);
        rom_addr_o  = instr_cnt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n    = state;
        cfg_core_o = '0;
        cfg_addr_o = '0;
        cfg_data_o = '0;
        case (state)
            e_reset: state_n = e_freeze;
            e_freeze: begin
                cfg_core_o = core_cnt;
                cfg_addr_o = freeze_addr;
                cfg_data_o = data_width_p'(1);
                if (hs && last_elem) state_n = e_core_id;
            end
            e_core_id: begin
                cfg_core_o = core_cnt;
                cfg_addr_o = core_id_addr;
                cfg_data_o = data_width_p'(core_cnt);
                if (hs && last_elem) state_n = e_ucode;
            end
            e_ucode: begin
                cfg_core_o = core_cnt;
                cfg_addr_o = ucode_base + (cfg_addr_width_p'(instr_cnt) << 3);
                cfg_data_o[cce_instr_width_p-1:0] = rom_data_i;
                if (hs && last_elem) state_n = e_mode;
            end
            e_mode: begin
                cfg_core_o = core_cnt;
                cfg_addr_o = cce_mode_addr;
                cfg_data_o = data_width_p'(1);
                if (hs && last_elem) state_n = e_drain;
            end
            e_drain: if (credits == '0) state_n = e_unfreeze;
            e_unfreeze: begin
                cfg_core_o = core_cnt;
                cfg_addr_o = freeze_addr;
                if (hs && last_elem) state_n = e_drain2;
            end
            e_drain2: if (credits == '0) state_n = e_done;
            e_done: state_n = e_done;
            default: state_n = e_reset;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= e_reset;
            core_cnt  <= '0;
            instr_cnt <= '0;
            credits   <= '0;
            rom_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (hs) begin
                if (last_elem) begin
                    core_cnt  <= '0;
                    instr_cnt <= '0;
                end else if (state == e_ucode) begin
                    if (last_instr) begin
                        instr_cnt <= '0;
                        core_cnt  <= core_cnt + core_w'(1);
                    end else begin
                        instr_cnt <= instr_cnt + instr_w'(1);
                    end
                end else begin
                    core_cnt <= core_cnt + core_w'(1);
                end
            end
            // ROM data is trusted one cycle after the address settles in e_ucode.
            rom_valid <= (state == e_ucode) && !hs;
            case ({hs, cfg_ack_i})
                2'b10:   credits <= credits + credit_w'(1);
                2'b01:   if (credits != '0) credits <= credits - credit_w'(1);
                default: credits <= credits;
            endcase
        end
    end

    ack_underflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
        !(cfg_ack_i && !hs && (credits == '0)));

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Scoreboard bench for bp_cfg_loader: expected writes are queued per run and a negedge
// monitor compares each handshake, stall stability, drain ordering and done timing.
module tb_bp_cfg_loader;

    localparam int N = 2, ELS = 4, CRED = 4;

    logic        clk_i = 1'b0, reset_i = 1'b1, cfg_ready_i = 1'b1, cfg_ack_i = 1'b0;
    logic [63:0] rom_data_i = '0;
    logic        cfg_v_o, done_o;
    logic [0:0]  cfg_core_o;
    logic [15:0] cfg_addr_o;
    logic [63:0] cfg_data_o;
    logic [1:0]  rom_addr_o;

    bp_cfg_loader #(
        .num_core_p(N), .cce_instr_ram_els_p(ELS), .cce_instr_width_p(64),
        .cfg_addr_width_p(16), .data_width_p(64), .max_credits_p(CRED)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .cfg_v_o(cfg_v_o), .cfg_ready_i(cfg_ready_i),
        .cfg_core_o(cfg_core_o), .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o),
        .cfg_ack_i(cfg_ack_i), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [0:0]  core;
        logic [15:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t sb[$];
    int  pend[$];
    int  passed = 0, total = 0;
    int  phase_writes = 0, out_cnt = 0, max_out = 0;
    int  ack_delay = 1;
    bit  ack_hold = 0, ack_one = 0, rand_ready = 0;
    bit  done_seen = 0, unfreeze_seen = 0, stalled = 0;
    wr_t held;

    task automatic check(input string name, input bit ok, input logic [95:0] act,
                         input logic [95:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic wr_t mk(input int c, input int a, input logic [63:0] d);
        wr_t w;
        w.core = 1'(c);
        w.addr = 16'(a);
        w.data = d;
        return w;
    endfunction

    task automatic push_all();
        for (int c = 0; c < N; c++) sb.push_back(mk(c, 'h0008, 64'd1));
        for (int c = 0; c < N; c++) sb.push_back(mk(c, 'h0010, 64'(c)));
        for (int c = 0; c < N; c++)
            for (int i = 0; i < ELS; i++)
                sb.push_back(mk(c, 'h8000 + 8 * i, 64'h0000_A000 + 64'(i)));
        for (int c = 0; c < N; c++) sb.push_back(mk(c, 'h0018, 64'd1));
        for (int c = 0; c < N; c++) sb.push_back(mk(c, 'h0008, 64'd0));
    endtask

    // Synchronous ROM model, one-cycle latency.
    initial forever begin
        @(posedge clk_i);
        rom_data_i <= 64'h0000_A000 + 64'(rom_addr_o);
    end

    initial forever begin
        @(posedge clk_i); #1;
        cfg_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Ack sink: each write is acked ack_delay cycles later, in order, one per cycle.
    initial forever begin
        @(posedge clk_i); #1;
        cfg_ack_i = 1'b0;
        if (reset_i) pend.delete();
        else begin
            foreach (pend[k]) if (pend[k] > 0) pend[k]--;
            if (pend.size() > 0 && pend[0] == 0 && (!ack_hold || ack_one)) begin
                void'(pend.pop_front());
                cfg_ack_i = 1'b1;
                ack_one   = 1'b0;
            end
        end
    end

    initial forever begin
        wr_t cur, exp;
        @(negedge clk_i);
        if (reset_i) begin
            out_cnt = 0;
            stalled = 0;
        end else begin
            cur = {cfg_core_o, cfg_addr_o, cfg_data_o};
            if (stalled)
                check("stall_stable", cfg_v_o && cur == held, {cfg_v_o, cur}, {1'b1, held});
            if (done_o && !done_seen) begin
                check("done_after_acks", out_cnt == 0 && sb.size() == 0, out_cnt, 0);
                done_seen = 1;
            end
            if (cfg_v_o && cfg_ready_i) begin
                if (sb.size() == 0) check("extra_write", 1'b0, cur, 0);
                else begin
                    exp = sb.pop_front();
                    check($sformatf("write_%0d", phase_writes), cur == exp, cur, exp);
                end
                if (cfg_addr_o == 16'h0008 && cfg_data_o == 64'd0 && !unfreeze_seen) begin
                    check("unfreeze_after_drain", out_cnt == 0, out_cnt, 0);
                    unfreeze_seen = 1;
                end
                phase_writes++;
                pend.push_back(ack_delay);
            end
            stalled = cfg_v_o && !cfg_ready_i;
            held    = cur;
            out_cnt = out_cnt + int'(cfg_v_o && cfg_ready_i) - int'(cfg_ack_i);
            if (out_cnt > max_out) max_out = out_cnt;
        end
    end

    task automatic start_run();
        sb.delete();
        push_all();
        phase_writes  = 0;
        done_seen     = 0;
        unfreeze_seen = 0;
        max_out       = 0;
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); #1;
        check("reset_outputs",
              {cfg_v_o, done_o, rom_addr_o, cfg_core_o, cfg_addr_o, cfg_data_o} == '0,
              {cfg_v_o, done_o, rom_addr_o, cfg_core_o, cfg_addr_o, cfg_data_o}, 0);
        start_run();
        @(posedge clk_i); #1;
        reset_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done_seen; i++) @(negedge clk_i);
        #1;
        check("done_reached", done_seen, done_seen, 1);
    endtask

    initial begin
        // Basic run: always ready, ack one cycle after each write.
        do_reset();
        wait_done(500);
        check("run1_writes", phase_writes == 16, phase_writes, 16);
        repeat (5) @(negedge clk_i);
        #1;
        check("done_sticky", done_o == 1'b1 && cfg_v_o == 1'b0, {done_o, cfg_v_o}, 2'b10);
        check("run1_credit_cap", max_out <= CRED, max_out, CRED);

        // Acks withheld: credit limit stops issue at exactly four writes.
        ack_hold = 1;
        do_reset();
        repeat (30) @(negedge clk_i);
        #1;
        check("hold_writes", phase_writes == 4, phase_writes, 4);
        check("hold_v_low", cfg_v_o == 1'b0, cfg_v_o, 0);
        ack_one = 1;
        @(negedge clk_i); #1;
        check("ack_in_flight_v_low", cfg_v_o == 1'b0, cfg_v_o, 0);
        @(negedge clk_i); #1;
        check("ack_frees_credit", cfg_v_o == 1'b1 && phase_writes == 5, {cfg_v_o, 8'(phase_writes)},
              {1'b1, 8'd5});
        repeat (5) @(negedge clk_i);
        #1;
        check("hold_again_writes", phase_writes == 5 && cfg_v_o == 1'b0, phase_writes, 5);
        ack_hold = 0;
        wait_done(1000);
        check("run2_writes", phase_writes == 16, phase_writes, 16);
        check("run2_credit_peak", max_out == CRED, max_out, CRED);

        // Random ready stalls.
        rand_ready = 1;
        do_reset();
        wait_done(2000);
        rand_ready = 0;
        check("run3_writes", phase_writes == 16, phase_writes, 16);

        // Slow acks: unfreeze must wait for the drain.
        ack_delay = 10;
        do_reset();
        wait_done(3000);
        check("run4_writes", phase_writes == 16, phase_writes, 16);
        check("run4_credit_cap", max_out <= CRED, max_out, CRED);
        ack_delay = 1;

        // Reset mid-ucode after c1 i1; sequence must restart and complete.
        do_reset();
        for (int i = 0; i < 200 && phase_writes < 10; i++) @(negedge clk_i);
        #1;
        check("reached_c1_i2", phase_writes == 10, phase_writes, 10);
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i); #1;
        check("mid_reset_idle", cfg_v_o == 1'b0 && done_o == 1'b0, {cfg_v_o, done_o}, 0);
        start_run();
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        wait_done(500);
        check("run5_writes", phase_writes == 16, phase_writes, 16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
